// File: rtl/alu_shift_arbiter_if.sv
// Requester/response bundle for alu_shift_arbiter: two requesters, shared 32-bit result bus.
interface alu_shift_arbiter_if;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 2;
  localparam int unsigned OW = 2;

  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0][OW-1:0] req_op;
  logic [NR-1:0][DW-1:0] req_x;
  logic [NR-1:0][DW-1:0] req_y;
  logic [NR-1:0]         rsp_valid;
  logic [NR-1:0]         rsp_ready;
  logic [DW-1:0]         rsp_z;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_shift_arbiter.sv
// Round-robin sharing of one 32-bit shifter between two requesters with a one-entry result buffer.
// Optional grant counters are enabled by defining ALU_SHIFT_ARB_STATS_EN.
module alu_shift_arbiter (
  input  logic                clk,
  input  logic                rst,
  alu_shift_arbiter_if.slave  bus
`ifdef ALU_SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`endif
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned CW = 16;

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [0:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] z_q, z_d;
  logic          err_q, err_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;

  logic          buf_free_c;
  logic          grant_c;
  logic          gidx_c;
  logic [1:0]    sel_op_c;
  logic [DW-1:0] sel_x_c;
  logic [DW-1:0] sel_y_c;
  logic [SW-1:0] sh_c;
  logic          oor_c;
  logic [DW-1:0] shift_z_c;
  logic          shift_err_c;

  // Buffer may accept when empty or when the owner drains it this cycle
  always_comb begin
    buf_free_c = (state_q == S_EMPTY) || bus.rsp_ready[owner_q];
    grant_c    = 1'b0;
    gidx_c     = 1'b0;
    if (!rst && buf_free_c) begin
      case (bus.req_valid)
        2'b01:   begin grant_c = 1'b1; gidx_c = 1'b0;          end
        2'b10:   begin grant_c = 1'b1; gidx_c = 1'b1;          end
        2'b11:   begin grant_c = 1'b1; gidx_c = ~last_grant_q; end
        default: begin grant_c = 1'b0; gidx_c = 1'b0;          end
      endcase
    end
  end

  assign bus.req_ready = {grant_c & gidx_c, grant_c & ~gidx_c};

  // Shift datapath on the granted requester's operands
  always_comb begin
    sel_op_c    = bus.req_op[gidx_c];
    sel_x_c     = bus.req_x[gidx_c];
    sel_y_c     = bus.req_y[gidx_c];
    sh_c        = sel_y_c[SW-1:0];
    oor_c       = |sel_y_c[DW-1:SW];
    shift_z_c   = '0;
    shift_err_c = 1'b0;
    case (sel_op_c)
      OP_SLL:  shift_z_c = oor_c ? '0 : (sel_x_c << sh_c);
      OP_SRL:  shift_z_c = oor_c ? '0 : (sel_x_c >> sh_c);
      OP_SRA:  shift_z_c = oor_c ? {DW{sel_x_c[DW-1]}}
                                 : DW'($signed(sel_x_c) >>> sh_c);
      default: shift_err_c = 1'b1;
    endcase
  end

  // Next-state for the result buffer and round-robin pointer
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    z_d          = z_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    if ((state_q == S_FULL) && bus.rsp_ready[owner_q]) begin
      state_d     = S_EMPTY;
      rsp_valid_d = 2'b00;
    end
    if (grant_c) begin
      state_d      = S_FULL;
      owner_d      = gidx_c;
      last_grant_d = gidx_c;
      z_d          = shift_z_c;
      err_d        = shift_err_c;
      rsp_valid_d  = {gidx_c, ~gidx_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      z_q          <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      z_q          <= z_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = z_q;
  assign bus.rsp_err   = err_q;

`ifdef ALU_SHIFT_ARB_STATS_EN
  logic [CW-1:0] cnt0_q, cnt1_q;

  // Saturating per-requester accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant_c && !gidx_c && (cnt0_q != {CW{1'b1}})) cnt0_q <= cnt0_q + CW'(1);
      if (grant_c &&  gidx_c && (cnt1_q != {CW{1'b1}})) cnt1_q <= cnt1_q + CW'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule
